// File: rtl/clock_overlay_renderer.sv
// clock_overlay_renderer
//   Two-stage pixel renderer for an HH:MM[:SS]-style time readout overlaid on
//   the VGA pixel stream. It draws NUM_FIELDS two-digit seven-segment fields,
//   with colon dots between them. The digit bus is captured once per frame
//   (on frame_tick), so a digit never changes partway down the screen. In
//   edit mode the selected field blinks in a highlight colour.
//
//   Optional feature: define COLON_BLINK_EN to blink the colons with the
//   blink phase and to hide them while in edit mode. When it is left
//   undefined, the colons are always visible.
//
// Ports
//   clk         in   pixel clock
//   reset_n     in   synchronous, active-low reset
//   video_on    in   active-video flag for pix_x/pix_y
//   pix_x       in   current pixel column (10 bit)
//   pix_y       in   current pixel row (10 bit)
//   frame_tick  in   1-cycle pulse at start of vertical blank
//   digits      in   BCD, field f = digits[8*(NUM_FIELDS-1-f)+:8], [7:4]=tens
//   edit_mode   in   1 = edit mode (selected field blinks)
//   edit_sel    in   index of the field to highlight
//   video_on_q  out  video_on delayed by 2 clk, aligned with graph_rgb
//   graph_rgb   out  12-bit pixel colour, 2 clk after pix_x/pix_y

module clock_overlay_renderer #(
  parameter int          NUM_FIELDS   = 3,
  parameter logic [9:0]  ORIGIN_X     = 10'd270,
  parameter logic [9:0]  ORIGIN_Y     = 10'd232,
  parameter int          DIGIT_W      = 12,
  parameter int          DIGIT_H      = 24,
  parameter int          COLON_W      = 8,
  parameter logic [11:0] FG_RGB       = 12'h000,
  parameter logic [11:0] HL_RGB       = 12'hF00,
  parameter logic [11:0] BG_RGB       = 12'hFFF,
  parameter int          BLINK_FRAMES = 30
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    video_on,
  input  logic [9:0]              pix_x,
  input  logic [9:0]              pix_y,
  input  logic                    frame_tick,
  input  logic [8*NUM_FIELDS-1:0] digits,
  input  logic                    edit_mode,
  input  logic [1:0]              edit_sel,
  output logic                    video_on_q,
  output logic [11:0]             graph_rgb
);

  localparam int OX          = int'(ORIGIN_X);
  localparam int OY          = int'(ORIGIN_Y);
  localparam int DIGIT_PITCH = DIGIT_W + 4;
  localparam int FIELD_PITCH = 2 * DIGIT_PITCH + COLON_W;
  localparam int HALF        = DIGIT_H / 2;
  localparam int CNT_W       = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  logic [8*NUM_FIELDS-1:0] digits_q;
  logic [CNT_W-1:0]        blink_cnt;
  logic                    blink_phase;

  logic       digit_on, colon_on;
  logic [1:0] field_idx;
  logic       vid_s1, digit_s1, colon_s1;
  logic [1:0] field_s1;
  logic       sel_valid, colon_vis;

  int px, py, cx, rx, ry;
  logic [6:0] segs;

  // Segment set {a,b,c,d,e,f,g} for one BCD nibble; non-decimal nibbles are blank.
  function automatic logic [6:0] seg_map(input logic [3:0] n);
    case (n)
      4'd0:    return 7'b1111110;
      4'd1:    return 7'b0110000;
      4'd2:    return 7'b1101101;
      4'd3:    return 7'b1111001;
      4'd4:    return 7'b0110011;
      4'd5:    return 7'b1011011;
      4'd6:    return 7'b1011111;
      4'd7:    return 7'b1110000;
      4'd8:    return 7'b1111111;
      4'd9:    return 7'b1111011;
      default: return 7'b0000000;
    endcase
  endfunction

  // True when cell-relative (x, y) lies on one of the enabled 2-px segments.
  function automatic logic seg_lit(input logic [6:0] s, input int x, input int y);
    logic lit;
    lit = 1'b0;
    if (s[6] && y <= 1)                            lit = 1'b1;
    if (s[5] && x >= DIGIT_W - 2 && y <= HALF)     lit = 1'b1;
    if (s[4] && x >= DIGIT_W - 2 && y >= HALF)     lit = 1'b1;
    if (s[3] && y >= DIGIT_H - 2)                  lit = 1'b1;
    if (s[2] && x <= 1 && y >= HALF)               lit = 1'b1;
    if (s[1] && x <= 1 && y <= HALF)               lit = 1'b1;
    if (s[0] && (y == HALF - 1 || y == HALF))      lit = 1'b1;
    return lit;
  endfunction

  // Frame-rate state. Digits are only sampled here, so a frame never tears.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      digits_q    <= '0;
      blink_cnt   <= '0;
      blink_phase <= 1'b1;
    end else if (frame_tick) begin
      digits_q <= digits;
      if (blink_cnt == CNT_W'(BLINK_FRAMES - 1)) begin
        blink_cnt   <= '0;
        blink_phase <= ~blink_phase;
      end else begin
        blink_cnt <= blink_cnt + CNT_W'(1);
      end
    end
  end

  // Hit test for the current pixel. Signed int arithmetic means coordinates
  // left of or above a cell simply fall out of range instead of wrapping.
  always_comb begin
    digit_on  = 1'b0;
    colon_on  = 1'b0;
    field_idx = 2'd0;
    segs      = 7'd0;
    px        = int'(pix_x);
    py        = int'(pix_y);
    cx        = 0;
    rx        = 0;
    ry        = py - OY;
    for (int f = 0; f < NUM_FIELDS; f++) begin
      for (int d = 0; d < 2; d++) begin
        cx = OX + f * FIELD_PITCH + d * DIGIT_PITCH;
        rx = px - cx;
        if (rx >= 0 && rx < DIGIT_W && ry >= 0 && ry < DIGIT_H) begin
          segs = seg_map(digits_q[8*(NUM_FIELDS-1-f) + 4*(1-d) +: 4]);
          if (seg_lit(segs, rx, ry)) begin
            digit_on  = 1'b1;
            field_idx = 2'(f);
          end
        end
      end
      if (f < NUM_FIELDS - 1) begin
        rx = px - (OX + f * FIELD_PITCH + 2 * DIGIT_PITCH);
        if (rx >= 3 && rx <= 4 &&
            (ry == HALF - 5 || ry == HALF - 4 || ry == HALF + 3 || ry == HALF + 4))
          colon_on = 1'b1;
      end
    end
  end

  // Stage 1: register the hit flags alongside video_on.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      vid_s1   <= 1'b0;
      digit_s1 <= 1'b0;
      colon_s1 <= 1'b0;
      field_s1 <= 2'd0;
    end else begin
      vid_s1   <= video_on;
      digit_s1 <= digit_on;
      colon_s1 <= colon_on;
      field_s1 <= field_idx;
    end
  end

  // An out-of-range edit_sel highlights nothing.
  always_comb begin
    sel_valid = ({1'b0, edit_sel} < 3'(NUM_FIELDS));
`ifdef COLON_BLINK_EN
    colon_vis = blink_phase && !edit_mode;
`else
    colon_vis = 1'b1;
`endif
  end

  // Stage 2: colour resolution in priority order.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      graph_rgb  <= 12'h000;
      video_on_q <= 1'b0;
    end else begin
      video_on_q <= vid_s1;
      if (!vid_s1)
        graph_rgb <= 12'h000;
      else if (digit_s1 && edit_mode && sel_valid && field_s1 == edit_sel)
        graph_rgb <= blink_phase ? HL_RGB : BG_RGB;
      else if (digit_s1 || (colon_s1 && colon_vis))
        graph_rgb <= FG_RGB;
      else
        graph_rgb <= BG_RGB;
    end
  end

endmodule
